// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state enum, forward-select codes and the load result-source code.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LDSTALL  = 2'b01,
        REDIRECT = 2'b10
    } haz_state_e;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

    localparam logic [1:0] RES_LOAD = 2'b01;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select decode for one Execute operand.
// Ports: rs (Execute source), rd_m/reg_write_m, rd_w/reg_write_w -> fwd select.
module hazard_fwd_sel (
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);
    import hazard_ctrl_pkg::*;

    // Memory is younger than Writeback, so it wins; x0 never forwards.
    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            fwd = FWD_M;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: stall/flush/forward controls plus load-use/redirect FSM.
// Ports: Clk, RstN, register ids per stage, ResSrcE, RegWriteM/W, PCSrcE in;
// StallF/D, FlushD/E, ForwardAE/BE, HazState out. With macro HAZARD_PERF_EN,
// CNT_W-wide saturating StallCnt/FlushCnt outputs are added.
module hazard_ctrl
`ifdef HAZARD_PERF_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic       Clk,
    input  logic       RstN,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic [1:0] ResSrcE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       PCSrcE,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic [1:0] HazState
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);
    import hazard_ctrl_pkg::*;

    haz_state_e state;
    haz_state_e state_nxt;
    logic       ld_use_raw;
    logic       ld_use;

    hazard_fwd_sel u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .fwd         (ForwardAE)
    );

    hazard_fwd_sel u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .fwd         (ForwardBE)
    );

    assign ld_use_raw = (ResSrcE == RES_LOAD) && (RdE != 5'd0)
                     && ((RdE == Rs1D) || (RdE == Rs2D));

    // Right after a redirect, Execute holds a bubble, so any
    // apparent load-use match is stale.
    assign ld_use = ld_use_raw && (state != REDIRECT);

    // A redirect flushes the dependent instruction, so no stall.
    assign StallF = ld_use && !PCSrcE;
    assign StallD = ld_use && !PCSrcE;
    assign FlushD = PCSrcE;
    assign FlushE = ld_use || PCSrcE;

    assign HazState = state;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = RUN;
        if (PCSrcE) begin
            state_nxt = REDIRECT;
        end else if (ld_use) begin
            state_nxt = LDSTALL;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallD && (StallCnt != '1)) begin
                StallCnt <= StallCnt + CNT_W'(1);
            end
            if (PCSrcE && (FlushCnt != '1)) begin
                FlushCnt <= FlushCnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, hand sequences
// for reset/saturation, and randomized stimulus against a reference model.
module tb_hazard_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic       Clk;
    logic       RstN;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResSrcE;
    logic       RegWriteM, RegWriteW, PCSrcE;
    logic       StallF, StallD, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE, HazState;
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] StallCnt, FlushCnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [4:0] rs1d;
        logic [4:0] rs2d;
        logic [4:0] rs1e;
        logic [4:0] rs2e;
        logic [4:0] rde;
        logic [4:0] rdm;
        logic [4:0] rdw;
        logic [1:0] res;
        logic       rwm;
        logic       rww;
        logic       pc;
    } in_t;

    typedef struct {
        int stall;
        int flushd;
        int flushe;
        int fwda;
        int fwdb;
        int st;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    // Reference model: remembers only what happened last cycle.
    int m_prev_pc;
    int m_prev_ld;
    int m_scnt;
    int m_fcnt;

`ifdef HAZARD_PERF_EN
    hazard_ctrl #(.CNT_W(CW)) dut (
`else
    hazard_ctrl dut (
`endif
        .Clk       (Clk),
        .RstN      (RstN),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdE       (RdE),
        .RdM       (RdM),
        .RdW       (RdW),
        .ResSrcE   (ResSrcE),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .PCSrcE    (PCSrcE),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .HazState  (HazState)
`ifdef HAZARD_PERF_EN
        ,
        .StallCnt  (StallCnt),
        .FlushCnt  (FlushCnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input int rs1d, input int rs2d,
                               input int rs1e, input int rs2e,
                               input int rde, input int rdm, input int rdw,
                               input int res, input int rwm, input int rww,
                               input int pc);
        in_t r;
        r.rs1d = 5'(rs1d); r.rs2d = 5'(rs2d);
        r.rs1e = 5'(rs1e); r.rs2e = 5'(rs2e);
        r.rde  = 5'(rde);  r.rdm  = 5'(rdm);  r.rdw = 5'(rdw);
        r.res  = 2'(res);  r.rwm  = 1'(rwm);  r.rww = 1'(rww);
        r.pc   = 1'(pc);
        return r;
    endfunction

    task automatic apply(input in_t x);
        Rs1D = x.rs1d; Rs2D = x.rs2d;
        Rs1E = x.rs1e; Rs2E = x.rs2e;
        RdE = x.rde; RdM = x.rdm; RdW = x.rdw;
        ResSrcE = x.res;
        RegWriteM = x.rwm; RegWriteW = x.rww;
        PCSrcE = x.pc;
    endtask

    function automatic int m_fwd(input int rs, input in_t x);
        if (x.rwm && x.rdm != 0 && int'(x.rdm) == rs) return 2;
        if (x.rww && x.rdw != 0 && int'(x.rdw) == rs) return 1;
        return 0;
    endfunction

    function automatic int m_ld(input in_t x);
        if (m_prev_pc != 0) return 0;
        return (x.res == 2'd1 && x.rde != 0
                && (x.rde == x.rs1d || x.rde == x.rs2d)) ? 1 : 0;
    endfunction

    function automatic int m_state();
        if (m_prev_pc != 0) return 2;
        if (m_prev_ld != 0) return 1;
        return 0;
    endfunction

    task automatic m_reset();
        m_prev_pc = 0; m_prev_ld = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    // Advance the model across the coming rising edge.
    task automatic m_commit(input in_t x);
        int ld;
        ld = m_ld(x);
        if (ld != 0 && !x.pc && m_scnt < CMAX) m_scnt++;
        if (x.pc && m_fcnt < CMAX) m_fcnt++;
        m_prev_pc = x.pc ? 1 : 0;
        m_prev_ld = ld;
    endtask

    task automatic m_check(input in_t x);
        int ld;
        int st;
        ld = m_ld(x);
        st = (ld != 0 && !x.pc) ? 1 : 0;
        chk("rnd_stallf", int'(StallF), st);
        chk("rnd_stalld", int'(StallD), st);
        chk("rnd_flushd", int'(FlushD), x.pc ? 1 : 0);
        chk("rnd_flushe", int'(FlushE), (ld != 0 || x.pc) ? 1 : 0);
        chk("rnd_fwda", int'(ForwardAE), m_fwd(int'(x.rs1e), x));
        chk("rnd_fwdb", int'(ForwardBE), m_fwd(int'(x.rs2e), x));
        chk("rnd_state", int'(HazState), m_state());
`ifdef HAZARD_PERF_EN
        chk("rnd_stallcnt", int'(StallCnt), m_scnt);
        chk("rnd_flushcnt", int'(FlushCnt), m_fcnt);
`endif
    endtask

    task automatic cyc(input in_t x);
        @(negedge Clk);
        apply(x);
        #2;
        m_check(x);
        m_commit(x);
    endtask

    vec_t vt[13];
    in_t  z;
    in_t  lu;
    in_t  r;

    initial begin
        z = mk(0,0,0,0,0,0,0,0,0,0,0);
        apply(z);
        RstN = 1'b0;
        m_reset();
        #2;
        chk("rst_state", int'(HazState), 0);
        chk("rst_stall", int'(StallD), 0);
        chk("rst_flushe", int'(FlushE), 0);
        chk("rst_fwda", int'(ForwardAE), 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        RstN = 1'b1;

        //           rs1d rs2d rs1e rs2e rde rdm rdw res rwm rww pc
        vt[0].i  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[0].e  = '{0, 0, 0, 0, 0, 0};
        vt[1].i  = mk(0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0);
        vt[1].e  = '{0, 0, 0, 2, 0, 0};
        vt[2].i  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        vt[2].e  = '{0, 0, 0, 0, 0, 0};
        vt[3].i  = mk(0, 0, 4, 3, 0, 4, 3, 0, 1, 1, 0);
        vt[3].e  = '{0, 0, 0, 2, 1, 0};
        vt[4].i  = mk(0, 0, 6, 0, 0, 6, 6, 0, 0, 1, 0);
        vt[4].e  = '{0, 0, 0, 1, 0, 0};
        vt[5].i  = mk(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0);
        vt[5].e  = '{1, 0, 1, 0, 0, 0};
        vt[6].i  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[6].e  = '{0, 0, 0, 0, 0, 1};
        vt[7].i  = mk(7, 0, 0, 0, 7, 0, 0, 1, 0, 0, 1);
        vt[7].e  = '{0, 1, 1, 0, 0, 0};
        vt[8].i  = mk(8, 0, 0, 0, 8, 0, 0, 1, 0, 0, 0);
        vt[8].e  = '{0, 0, 0, 0, 0, 2};
        vt[9].i  = mk(8, 0, 0, 0, 8, 0, 0, 1, 0, 0, 0);
        vt[9].e  = '{1, 0, 1, 0, 0, 0};
        vt[10].i = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[10].e = '{0, 0, 0, 0, 0, 1};
        vt[11].i = mk(9, 0, 0, 0, 9, 0, 0, 2, 0, 0, 0);
        vt[11].e = '{0, 0, 0, 0, 0, 0};
        vt[12].i = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        vt[12].e = '{0, 0, 0, 0, 0, 0};

        for (int k = 0; k < 13; k++) begin
            @(negedge Clk);
            apply(vt[k].i);
            #2;
            chk($sformatf("v%0d_stallf", k), int'(StallF), vt[k].e.stall);
            chk($sformatf("v%0d_stalld", k), int'(StallD), vt[k].e.stall);
            chk($sformatf("v%0d_flushd", k), int'(FlushD), vt[k].e.flushd);
            chk($sformatf("v%0d_flushe", k), int'(FlushE), vt[k].e.flushe);
            chk($sformatf("v%0d_fwda", k), int'(ForwardAE), vt[k].e.fwda);
            chk($sformatf("v%0d_fwdb", k), int'(ForwardBE), vt[k].e.fwdb);
            chk($sformatf("v%0d_state", k), int'(HazState), vt[k].e.st);
            m_commit(vt[k].i);
        end
`ifdef HAZARD_PERF_EN
        #1;
        chk("tbl_stallcnt", int'(StallCnt), 2);
        chk("tbl_flushcnt", int'(FlushCnt), 1);
`endif

        // Async reset while in LDSTALL.
        lu = mk(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0);
        @(negedge Clk);
        apply(lu);
        @(posedge Clk);
        #2;
        chk("ar_pre_state", int'(HazState), 1);
        #1;
        RstN = 1'b0;
        #1;
        chk("ar_state", int'(HazState), 0);
`ifdef HAZARD_PERF_EN
        chk("ar_stallcnt", int'(StallCnt), 0);
        chk("ar_flushcnt", int'(FlushCnt), 0);
`endif
        apply(z);
        m_reset();
        @(negedge Clk);
        RstN = 1'b1;
        #2;
        chk("ar_post_stall", int'(StallD), 0);
        chk("ar_post_state", int'(HazState), 0);
        cyc(z);

        // Back-to-back load-use: stalls every cycle, counter saturates.
        for (int k = 0; k < 20; k++) cyc(lu);
        @(negedge Clk);
        apply(z);
        #2;
        chk("sat_state", int'(HazState), 1);
`ifdef HAZARD_PERF_EN
        chk("sat_stallcnt", int'(StallCnt), CMAX);
`endif
        m_commit(z);

        for (int k = 0; k < 400; k++) begin
            r = mk($urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1),
                   ($urandom_range(0, 4) == 0) ? 1 : 0);
            cyc(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core. It generates the stall, flush and forwarding controls consumed by the stage registers. Its FlushE output drives the CLR input of the Decode→Execute control register. A small FSM tracks load-use bubbles and branch/jump redirects, and optional performance counters record each event.

## Interface
Parameters:
- CNT_W, 32: width of performance counters (only with HAZARD_PERF_EN)

Ports:
- Clk  in  1  core clock, rising edge
- RstN  in  1  asynchronous active-low reset
- Rs1D, Rs2D  in  5  source registers of the instruction in Decode
- Rs1E, Rs2E  in  5  source registers of the instruction in Execute
- RdE, RdM, RdW  in  5  destination registers in Execute, Memory and Writeback
- ResSrcE  in  2  result-source select in Execute; 2'b01 = load
- RegWriteM, RegWriteW  in  1  register-write enables in Memory and Writeback
- PCSrcE  in  1  taken branch, jal or jalr resolved in Execute
- StallF, StallD  out  1  hold PC and the Fetch→Decode register
- FlushD  out  1  clear the Fetch→Decode register
- FlushE  out  1  clear the Decode→Execute data and control registers (CLR)
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 = register file, 10 = ALU result from Memory, 01 = result from Writeback
- HazState  out  2  current FSM state (debug)
- StallCnt, FlushCnt  out  CNT_W  event counters (only with HAZARD_PERF_EN)

## Operation
- Forwarding (combinational): for each Execute source, ForwardxE = 10 when RegWriteM, RdM≠0 and RdM matches the source. Otherwise 01 when RegWriteW, RdW≠0 and RdW matches. Otherwise 00. Memory has priority over Writeback. Register x0 is never forwarded.
- Load-use detect (combinational): LdUse = (ResSrcE==2'b01) && RdE≠0 && (RdE==Rs1D || RdE==Rs2D).
- Redirect: PCSrcE=1 asserts FlushD and FlushE.
- Output equations:
  - StallF = StallD = LdUse && !PCSrcE
  - FlushD = PCSrcE
  - FlushE = LdUse || PCSrcE
- PCSrcE has priority over LdUse. The load-dependent instruction in Decode is flushed anyway, so no stall is issued.
- FSM states, 2-bit encoding:
  - RUN = 00
  - LDSTALL = 01
  - REDIRECT = 10
  - 11 is unused and returns to RUN.
- Transitions, evaluated every cycle from any state:
  - PCSrcE → REDIRECT
  - else LdUse → LDSTALL
  - else → RUN
- LDSTALL and REDIRECT last exactly one cycle unless the triggering condition repeats.
- In REDIRECT, LdUse is masked: Execute holds a bubble and Decode holds the new-path fetch. PCSrcE is still honoured.

## Timing
- Stall, flush and forward outputs are combinational from the inputs, in the same cycle. HazState is registered.
- Load-use case:
  - Cycle N: load in E, consumer in D. StallF = StallD = FlushE = 1.
  - Cycle N+1: bubble in E, load in M, consumer still in D. HazState = LDSTALL. No stall.
  - Cycle N+2: consumer in E. ForwardxE = 01 from Writeback.
- Redirect case:
  - Cycle N: PCSrcE = 1, so FlushD = FlushE = 1.
  - Cycle N+1: HazState = REDIRECT. No stall.
- Reset: HazState = RUN and counters = 0. Combinational outputs follow their inputs; with all-zero inputs, every output is 0.
- Reset asserted mid-stall: the state clears immediately and asynchronously. There is no residual stall after release.

## Configuration
- HAZARD_PERF_EN defined: StallCnt and FlushCnt ports exist.
  - StallCnt increments on each cycle with StallD = 1.
  - FlushCnt increments on each cycle with PCSrcE = 1.
  - Both saturate at all-ones and never wrap.
  - Both are cleared by RstN.
- HAZARD_PERF_EN undefined: the counter ports and logic are absent. All other behaviour is identical.

## Structure
- The shared package holds:
  - the hazard state enum (RUN, LDSTALL, REDIRECT)
  - forward-select constants FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10
  - RES_LOAD = 2'b01
- Sub-module hazard_fwd_sel: a combinational forward-select mux decode, instantiated twice (operands A and B). The FSM and counters stay in the top module.

## Test plan
- Forward from Memory: RdM = 5, RegWriteM = 1, Rs1E = 5, RdW = 5, RegWriteW = 1 → ForwardAE = 10 (Memory wins), ForwardBE = 00.
- x0 guard: RdM = 0, RegWriteM = 1, Rs1E = 0 → ForwardAE = 00.
- Load-use: ResSrcE = 01, RdE = 7, Rs2D = 7 →
  - same cycle: StallF = StallD = FlushE = 1, FlushD = 0
  - next cycle: HazState = 01, stalls = 0
- Redirect over load-use: PCSrcE = 1 together with a load-use match → FlushD = FlushE = 1, StallF = StallD = 0, HazState = 10 on the next edge.
- Async reset in LDSTALL: drop RstN mid-cycle → HazState = 00 before the next edge. StallCnt = 0 with HAZARD_PERF_EN.
- Counter saturation (CNT_W = 4, HAZARD_PERF_EN): 20 consecutive load-use cycles → StallCnt holds 4'hF.
